clct_busy_sep_ctrl: RTL
=======================

Name: clct_busy_sep_ctrl

Overview:
- Sits directly downstream of the 32-key best-of-N pattern sorter and closes the loop back into its busy input.
- Qualifies the sorter's best candidate and latches it as the first CLCT (clct1).
- Then drives a registered busy-key mask around clct1's key for a programmable hold window, so the sorter's next results exclude that region.
- Captures the first qualifying non-busy candidate in that window as the second CLCT (clct2).

Parameters:
MXKEY, 32, keys covered; width of busy mask
MXKEYB, 5, key number width (log2 MXKEY)
MXPATB, 7, pattern word width: [6:4] hit count, [3:1] pattern rank, [0] bend direction
MXPATC, 12, carry word width (opaque, passed through)
MXHOLD, 4, hold counter width

Ports:
clock  in  1  main clock
reset_n  in  1  asynchronous active-low reset
cand_vld  in  1  sorter output valid this cycle
best_pat  in  MXPATB  sorter best pattern
best_key  in  MXKEYB  sorter best key
best_carry  in  MXPATC  sorter best carry
best_bsy  in  1  sorter best candidate sits in a busy key
hit_thresh  in  3  minimum hits (best_pat[6:4]) to qualify
sep  in  MXKEYB  half-width of busy region in keys
hold_bx  in  MXHOLD  hold window length minus one, in clocks
clr  in  1  synchronous abort: return to IDLE, clear mask
bsy  out  MXKEY  registered busy-key mask, fed back to sorter
clct1_vld  out  1  one-clock pulse: first CLCT latched
clct1_pat / clct1_key / clct1_carry  out  MXPATB / MXKEYB / MXPATC  first CLCT, held until next clct1
clct2_vld  out  1  one-clock pulse: second CLCT latched
clct2_pat / clct2_key / clct2_carry  out  MXPATB / MXKEYB / MXPATC  second CLCT, held until next clct2
busy_state  out  1  high while in HOLD

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; bsy=0; all vld=0; all pat/key/carry=0; hold counter=0.
- Qualify: qual = cand_vld & !best_bsy & (best_pat[6:4] >= hit_thresh).
- IDLE:
  - on qual, next edge registers clct1_* from inputs, pulses clct1_vld, loads hold counter with hold_bx, enters HOLD.
  - Same edge sets bsy[k]=1 for max(0,key-sep) <= k <= min(MXKEY-1,key+sep); all other bits 0.
  - Latency from qualifying input to clct1_vld and to mask: 1 clock.
- HOLD:
  - Counter decrements each clock; HOLD lasts hold_bx+1 clocks; bsy held constant throughout.
  - First qual in HOLD latches clct2_* and pulses clct2_vld next edge. Further quals in the same HOLD are ignored (one clct2 per window).
  - When counter=0 at an edge: next state IDLE, bsy=0 on that same edge.
  - A qual arriving on the terminal HOLD cycle is treated as clct2, not as a new clct1.
- IDLE resumes accepting clct1 on the first cycle after HOLD exits.
- clr: highest priority after reset. Next edge gives IDLE, bsy=0, no vld pulse even if qual coincides. Latched pat/key/carry are retained.
- Arithmetic: clamp computations use MXKEYB+1 bits, no wrap. sep >= MXKEY gives an all-ones mask. sep=0 masks only the key itself.
- Candidates with cand_vld=0 have no effect; best_* are don't-care.
- best_pat[0] is ignored for qualification.

Optional Feature:
- Macro: CLCT_BEND_WIDEN_EN.
- Defined: the busy region extends one extra key on the bend side of clct1. If clct1_pat[0]=1, upper bound is key+sep+1; if 0, lower bound is key-sep-1. Same clamping rules apply.
- Undefined: region is symmetric, key±sep.

Test Plan:
1. Reset then release, no inputs -> bsy=0, no vld pulses, busy_state=0 for 100 clocks.
2. hit_thresh=3, sep=2, hold_bx=4; cand_vld with best_pat=7'h5A, key=10, bsy=0 -> next clock clct1_vld=1, clct1_key=10, bsy=32'h00001F00; busy_state high for exactly 5 clocks, then bsy=0.
3. Same setup; second qual (pat hits=4, key=20) on the 2nd HOLD clock, third qual key=25 on the 3rd -> one clct2_vld with clct2_key=20; key 25 ignored.
4. Boundary clamp: key=1, sep=3 -> bsy=32'h0000001F. Key=31, sep=3 -> bsy=32'hF0000000. sep=31 -> all ones.
5. clr asserted on 2nd HOLD clock together with a qual -> next clock IDLE, bsy=0, clct2_vld stays 0. Also reset_n low mid-HOLD -> immediate asynchronous clear of bsy and busy_state.
6. With CLCT_BEND_WIDEN_EN, key=10, sep=2: pat[0]=1 -> bsy=32'h00003F00; pat[0]=0 -> bsy=32'h00001F80. Low-hit (hits=2 < 3) or best_bsy=1 candidates never produce clct1.

Source files
------------

// File: rtl/clct_busy_sep_ctrl.sv
// CLCT busy-key separation controller: latches the first CLCT, then masks keys
// around it for a hold window and captures a second CLCT. Option: CLCT_BEND_WIDEN_EN.
module clct_busy_sep_ctrl #(
  parameter int MXKEY  = 32,
  parameter int MXKEYB = 5,
  parameter int MXPATB = 7,
  parameter int MXPATC = 12,
  parameter int MXHOLD = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cand_vld,
  input  logic [MXPATB-1:0] best_pat,
  input  logic [MXKEYB-1:0] best_key,
  input  logic [MXPATC-1:0] best_carry,
  input  logic              best_bsy,
  input  logic [2:0]        hit_thresh,
  input  logic [MXKEYB-1:0] sep,
  input  logic [MXHOLD-1:0] hold_bx,
  input  logic              clr,
  output logic [MXKEY-1:0]  bsy,
  output logic              clct1_vld,
  output logic [MXPATB-1:0] clct1_pat,
  output logic [MXKEYB-1:0] clct1_key,
  output logic [MXPATC-1:0] clct1_carry,
  output logic              clct2_vld,
  output logic [MXPATB-1:0] clct2_pat,
  output logic [MXKEYB-1:0] clct2_key,
  output logic [MXPATC-1:0] clct2_carry,
  output logic              busy_state
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [MXKEYB:0]   KEY_MAX  = (MXKEYB+1)'(MXKEY - 1);
  localparam logic [MXKEYB:0]   EXT_ZERO = '0;
  localparam logic [MXHOLD-1:0] HOLD_ONE = MXHOLD'(1);

  state_t            state_reg, state_next;
  logic [MXHOLD-1:0] hold_cnt_reg;
  logic              clct2_done_reg;

  logic              qual;
  logic              load1, load2, hold_end;
  logic [MXKEYB:0]   key_ext, sep_ext;
  logic [MXKEYB:0]   lo_span, hi_span, hi_sum;
  logic [MXKEYB:0]   lo_bound, hi_bound;
  logic [MXKEY-1:0]  mask_next;

  // Hit count lives in the top three bits of the pattern word; bend bit is not a factor.
  assign qual = cand_vld & ~best_bsy & (best_pat[MXPATB-1 -: 3] >= hit_thresh);

  // Region bounds, one bit wider than a key so key+sep cannot wrap.
  assign key_ext = {1'b0, best_key};
  assign sep_ext = {1'b0, sep};

`ifdef CLCT_BEND_WIDEN_EN
  assign lo_span = sep_ext + {EXT_ZERO[MXKEYB:1], ~best_pat[0]};
  assign hi_span = sep_ext + {EXT_ZERO[MXKEYB:1],  best_pat[0]};
`else
  assign lo_span = sep_ext;
  assign hi_span = sep_ext;
`endif

  assign hi_sum   = key_ext + hi_span;
  assign lo_bound = (lo_span > key_ext) ? EXT_ZERO : (key_ext - lo_span);
  assign hi_bound = (hi_sum > KEY_MAX) ? KEY_MAX : hi_sum;

  generate
    for (genvar gi = 0; gi < MXKEY; gi++) begin : g_mask
      assign mask_next[gi] = ((MXKEYB+1)'(gi) >= lo_bound) &&
                             ((MXKEYB+1)'(gi) <= hi_bound);
    end
  endgenerate

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; clr overrides everything but reset.
  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (qual) state_next = HOLD;
        HOLD:    if (hold_cnt_reg == '0) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    load1      = 1'b0;
    load2      = 1'b0;
    hold_end   = 1'b0;
    busy_state = (state_reg == HOLD);
    if (!clr) begin
      load1    = (state_reg == IDLE) & qual;
      load2    = (state_reg == HOLD) & qual & ~clct2_done_reg;
      hold_end = (state_reg == HOLD) & (hold_cnt_reg == '0);
    end
  end

  // Hold window counter and mask; a second CLCT is allowed once per window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_reg   <= '0;
      clct2_done_reg <= 1'b0;
      bsy            <= '0;
    end else if (clr) begin
      hold_cnt_reg   <= '0;
      clct2_done_reg <= 1'b0;
      bsy            <= '0;
    end else if (load1) begin
      hold_cnt_reg   <= hold_bx;
      clct2_done_reg <= 1'b0;
      bsy            <= mask_next;
    end else if (state_reg == HOLD) begin
      if (load2) clct2_done_reg <= 1'b1;
      if (hold_end) begin
        bsy <= '0;
      end else begin
        hold_cnt_reg <= hold_cnt_reg - HOLD_ONE;
      end
    end
  end

  // Captured CLCT words, retained across clr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clct1_vld   <= 1'b0;
      clct1_pat   <= '0;
      clct1_key   <= '0;
      clct1_carry <= '0;
      clct2_vld   <= 1'b0;
      clct2_pat   <= '0;
      clct2_key   <= '0;
      clct2_carry <= '0;
    end else begin
      clct1_vld <= load1;
      clct2_vld <= load2;
      if (load1) begin
        clct1_pat   <= best_pat;
        clct1_key   <= best_key;
        clct1_carry <= best_carry;
      end
      if (load2) begin
        clct2_pat   <= best_pat;
        clct2_key   <= best_key;
        clct2_carry <= best_carry;
      end
    end
  end

endmodule
